// File: rtl/sample_sched_pkg.sv
// Shared types and helpers for the sample bus scheduler.
// State encoding, clog2 helper and channel-index width derivation.
package sample_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ch_w_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sample_sched_rr_pick.sv
// rr_pick: combinational rotate-priority arbiter.
// Searches ptr+1, ptr+2, ... modulo N_CH and grants the first request.
module rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    int idx;

    // First requester after ptr, wrapping around
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!any && req[idx]) begin
                any       = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sample_sched_rr.sv
// sample_sched_rr: paced round-robin scheduler onto one sample bus.
// Define SAMPLE_SCHED_TDM_EN for fixed TDM slots instead of round-robin.
module sample_sched_rr
    import sample_sched_pkg::*;
#(
    parameter int DATA_WDT = 16,
    parameter int N_CH     = 4,
    parameter int SLOT_DIV = 4,
    localparam int CH_W    = ch_w_of(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_WDT-1:0] in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_WDT-1:0]      out_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy
);

    localparam int CNT_W = clog2(SLOT_DIV) + 1;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    hold_cnt, cnt_nx;
    logic [CH_W-1:0]     sel_idx;
    logic [N_CH-1:0]     sel_oh;
    logic                sel_ok;
    logic [DATA_WDT-1:0] sel_data;
    logic                grant_ok;
    logic                xfer;
    logic                slot_start;

    assign grant_ok = (state == ST_IDLE) && en && !rst;
    assign xfer     = |(in_valid & in_ready);
    assign busy     = (state == ST_HOLD);

`ifdef SAMPLE_SCHED_TDM_EN
    logic [CH_W-1:0] tdm_idx;

    // Fixed slot: only the current TDM channel is offered
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_oh[i] = (tdm_idx == CH_W'(i));
        end
        sel_idx = tdm_idx;
        sel_ok  = 1'b1;
    end

    // Every slot consumes a frame position, used or not
    assign slot_start = grant_ok;

    // Slot index advances once per offered slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdm_idx <= '0;
        end else if (grant_ok) begin
            if (tdm_idx == CH_W'(N_CH - 1)) tdm_idx <= '0;
            else                            tdm_idx <= tdm_idx + CH_W'(1);
        end
    end
`else
    logic [CH_W-1:0] rr_ptr;

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (sel_oh),
        .gnt_idx (sel_idx),
        .any     (sel_ok)
    );

    // Only a real transfer opens a slot
    assign slot_start = xfer;

    // Priority rotates past the channel just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= CH_W'(N_CH - 1);
        end else if (xfer) begin
            rr_ptr <= sel_idx;
        end
    end
`endif

    // Grant is combinational, gated by state, en and reset
    always_comb begin
        in_ready = '0;
        if (grant_ok && sel_ok) in_ready = sel_oh;
    end

    // Word of the selected channel, passed through untouched
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_idx == CH_W'(i)) begin
                sel_data = in_data[i*DATA_WDT +: DATA_WDT];
            end
        end
    end

    // Next state and hold countdown
    always_comb begin
        state_nx = state;
        cnt_nx   = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                if (slot_start) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = CNT_W'(SLOT_DIV - 1);
                end
            end
            ST_HOLD: begin
                cnt_nx = hold_cnt - CNT_W'(1);
                if (hold_cnt == CNT_W'(1)) state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= cnt_nx;
        end
    end

    // Output word held until next accept; valid is a one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_ch   <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_sample_sched_rr.sv
// Directed bench for sample_sched_rr.
// Round-robin checks by default; TDM checks when SAMPLE_SCHED_TDM_EN is set.
module tb_sample_sched_rr;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        busy;

    int n_chk;
    int n_pass;

    sample_sched_rr #(
        .DATA_WDT (16),
        .N_CH     (4),
        .SLOT_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_data();
        for (int i = 0; i < 4; i++) begin
            in_data[i*16 +: 16] = 16'(16'h0100 * i);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        en       = 1'b1;
        in_valid = 4'hF;
        in_data  = '0;
        ramp_data();
        repeat (3) tick();

        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_ch", 32'(out_ch), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

`ifdef SAMPLE_SCHED_TDM_EN
        in_valid = 4'b0010;
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk($sformatf("tdm_valid_%0d", k), 32'(out_valid),
                32'((k % 16) == 5));
            if ((k % 16) == 5) chk("tdm_ch", 32'(out_ch), 32'h1);
        end
`else
        rst = 1'b0;
        #1;
        chk("first_ready", 32'(in_ready), 32'h1);

        // All valid: 0,1,2,3,0 exactly four clocks apart
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("all_valid", 32'(out_valid), 32'h1);
            chk("all_ch", 32'(out_ch), 32'(s % 4));
            chk("all_data", 32'(out_data), 32'(16'h0100 * (s % 4)));
            chk("all_busy", 32'(busy), 32'h1);
            for (int h = 0; h < 3; h++) begin
                tick();
                chk("all_gap", 32'(out_valid), 32'h0);
            end
            chk("all_next", 32'(in_ready), 32'(1 << ((s + 1) % 4)));
        end

        // Single requester ch2 with -5
        in_valid = 4'b0100;
        in_data[32 +: 16] = 16'hFFFB;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("solo_ready", 32'(in_ready), 32'h4);
            tick();
            chk("solo_valid", 32'(out_valid), 32'h1);
            chk("solo_data", 32'(out_data), 32'hFFFB);
            chk("solo_ch", 32'(out_ch), 32'h2);
            for (int h = 0; h < 3; h++) begin
                chk("solo_noready", 32'(in_ready), 32'h0);
                tick();
            end
        end

        // en dropped during HOLD
        ramp_data();
        in_valid = 4'b0010;
        #1;
        chk("en_ready0", 32'(in_ready), 32'h2);
        tick();
        chk("en_acc", 32'(out_valid), 32'h1);
        chk("en_ch", 32'(out_ch), 32'h1);
        tick();
        en = 1'b0;
        #1;
        chk("en_busy", 32'(busy), 32'h1);
        tick();
        tick();
        chk("en_idle", 32'(busy), 32'h0);
        for (int h = 0; h < 4; h++) begin
            chk("en_off_ready", 32'(in_ready), 32'h0);
            tick();
            chk("en_off_valid", 32'(out_valid), 32'h0);
        end
        en = 1'b1;
        #1;
        chk("en_rise_ready", 32'(in_ready), 32'h2);
        tick();
        chk("en_rise_valid", 32'(out_valid), 32'h1);
        chk("en_rise_data", 32'(out_data), 32'h0100);

        // Reset while hold_cnt == 2
        tick();
        chk("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_data", 32'(out_data), 32'h0);
        chk("mid_ch", 32'(out_ch), 32'h0);
        chk("mid_busy0", 32'(busy), 32'h0);
        chk("mid_ready", 32'(in_ready), 32'h0);
        in_valid = 4'hF;
        tick();
        chk("mid_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'h1);
        tick();
        chk("rel_valid", 32'(out_valid), 32'h1);
        chk("rel_ch", 32'(out_ch), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_sched_rr.md
Name: sample_sched_rr

Overview:
- Round-robin scheduler sharing one sample bus between N_CH requester streams (modem channels, test generators) ahead of the cross-clock sample transfer stage.
- Paces transfers so a new word is presented at most once every SLOT_DIV clocks. This lets the slow-side capture, which samples every other destination clock, see every word exactly once.
- Outputs a held data word, a one-cycle valid strobe, and the source channel index.

Parameters:
- DATA_WDT, 16, sample width in bits (signed).
- N_CH, 4, number of requesters (2..16).
- SLOT_DIV, 4, minimum clocks between accepted words (>=2).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  grant enable; low blocks new grants only.
- in_valid  in  N_CH  per-channel word-valid.
- in_data  in  N_CH*DATA_WDT  packed signed samples; channel i at [i*DATA_WDT +: DATA_WDT].
- in_ready  out  N_CH  one-hot accept, combinational.
- out_data  out  DATA_WDT  signed; held until next accept.
- out_valid  out  1  one-cycle strobe per accepted word.
- out_ch  out  CH_W  channel of out_data; CH_W = max(1, clog2(N_CH)).
- busy  out  1  high while in HOLD.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, out_ch=0, busy=0, state=IDLE, hold_cnt=0, rr_ptr=N_CH-1. The first search therefore starts at ch0.
- in_ready is 0 while rst is high.
- FSM has two states:
  - IDLE:
    - When en=1 and any in_valid is set, the arbiter picks the first valid channel searching rr_ptr+1, rr_ptr+2, … modulo N_CH.
    - in_ready = one-hot of the pick, driven combinationally in the same cycle. A transfer happens when in_valid&in_ready.
    - On transfer, next edge: out_data<=in_data[pick], out_ch<=pick, out_valid<=1, rr_ptr<=pick, hold_cnt<=SLOT_DIV-1, state->HOLD.
    - With en=0 or no valid: in_ready=0 and state is unchanged.
  - HOLD:
    - in_ready=0, busy=1, out_valid=0 after its first cycle. hold_cnt decrements each clock.
    - When hold_cnt==1: state->IDLE.
    - en is ignored; a HOLD always completes.
- Latency: accept at edge t gives out_valid/out_data at t+1. Back-to-back accepts are exactly SLOT_DIV clocks apart.
- Requester may drop in_valid before acceptance; no grant is issued and nothing is queued.
- A single requester is served on every slot. rr_ptr updates only on an actual transfer.
- No arithmetic on data; bit-exact pass-through, sign preserved.
- rst mid-HOLD: immediate return to reset values; the in-flight word is not re-emitted.

Optional Feature:
- Macro: SAMPLE_SCHED_TDM_EN.
- Defined (fixed TDM mode):
  - Arbiter replaced by slot index tdm_idx (reset 0).
  - In IDLE with en=1, only channel tdm_idx may be readied, for exactly one cycle.
  - If that channel is valid, the transfer proceeds as above. If not, there is no transfer and no out_valid.
  - Either way: tdm_idx<=tdm_idx+1 modulo N_CH, state->HOLD for SLOT_DIV-1 clocks. This gives a fixed frame of N_CH*SLOT_DIV clocks.
  - With en=0, tdm_idx is frozen.
- Undefined: round-robin as specified.

Decomposition:
- Package sample_sched_pkg holds:
  - state encoding (ST_IDLE, ST_HOLD);
  - a clog2 constant function;
  - the CH_W derivation.
- One sub-module, rr_pick: combinational rotate-priority arbiter.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: gnt one-hot, gnt_idx, any.
  - Not instantiated when SAMPLE_SCHED_TDM_EN is defined.

Test Plan:
- Reset: rst=1 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0. After release the first accept is ch0.
- All 4 valid, data ch_i=16'h0100*i, en=1 -> out_ch sequence 0,1,2,3,0. out_valid pulses exactly 4 clocks apart; out_data matches.
- Only ch2 valid with data -5 -> accepted every 4 clocks, out_data=16'hFFFB, out_ch=2. in_ready[0,1,3] never high.
- en dropped on 2nd HOLD cycle -> HOLD completes, no accept while en=0. en rise with ch1 valid -> in_ready[1] in that same cycle, out_valid next clock.
- rst asserted at hold_cnt=2 -> outputs zero immediately, busy=0. After release, all valid -> ch0 first again.
- TDM build, only ch1 valid continuously -> out_valid once per 16 clocks, always out_ch=1. No out_valid in slots 0, 2, 3.
